// File: rtl/shared_inv_gf4_backend_if.sv
// Operand/result bundle for the masked GF(2^4) inversion back-end.
// Share i of every bus sits at the low-to-high slice position i.
interface shared_inv_gf4_backend_if #(
    parameter int unsigned SHARES = 2
);
    logic                            ValidxSI;
    logic [4*SHARES-1:0]             _AxDI;
    logic [2*SHARES-1:0]             _DxDI;
    logic [2*SHARES*(SHARES-1)-1:0]  _ZxDI;
    logic [4*SHARES-1:0]             _QxDO;
    logic                            ValidxSO;

    modport master (
        output ValidxSI, _AxDI, _DxDI, _ZxDI,
        input  _QxDO, ValidxSO
    );

    modport slave (
        input  ValidxSI, _AxDI, _DxDI, _ZxDI,
        output _QxDO, ValidxSO
    );
endinterface

// File: rtl/shared_inv_gf4_backend.sv
// DOM back-end of the masked GF(2^4) inverter: per-share GF(2^2) inversion of d,
// then two DOM-indep multipliers producing {e*a0, e*a1} one cycle after d arrives.
module shared_inv_gf4_backend #(
    parameter int unsigned SHARES    = 2,
    parameter int unsigned D_LATENCY = 1
) (
    input logic                     ClkxCI,
    input logic                     RstxRI,
    shared_inv_gf4_backend_if.slave bus
);
    localparam int unsigned AW    = 4 * SHARES;
    localparam int unsigned PAIRS = SHARES * (SHARES - 1) / 2;
    localparam int unsigned ZHALF = 2 * PAIRS;

    // Normal-basis GF(2^2) product
    function automatic logic [1:0] gf4Mul(input logic [1:0] a, input logic [1:0] b);
        logic t;
        t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
    endfunction

    // Row-major index of share pair (i, j), i < j
    function automatic int pairIndex(input int i, input int j);
        return (i * (2 * SHARES - i - 1)) / 2 + (j - i - 1);
    endfunction

    logic [AW-1:0] aDelayed;

    if (D_LATENCY == 0) begin : g_noDelay
        assign aDelayed = bus._AxDI;
    end else begin : g_delay
        logic [D_LATENCY-1:0][AW-1:0] aStage;

        // Align a1/a0 with the upstream square-scale-multiply latency
        always_ff @(posedge ClkxCI) begin
            if (RstxRI) begin
                aStage <= '0;
            end else begin
                aStage[0] <= bus._AxDI;
                for (int s = 1; s < D_LATENCY; s++) begin
                    aStage[s] <= aStage[s-1];
                end
            end
        end

        assign aDelayed = aStage[D_LATENCY-1];
    end

    logic [D_LATENCY:0] validPipe;

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            validPipe <= '0;
        end else begin
            validPipe[0] <= bus.ValidxSI;
            for (int s = 1; s <= D_LATENCY; s++) begin
                validPipe[s] <= validPipe[s-1];
            end
        end
    end

    assign bus.ValidxSO = validPipe[D_LATENCY];

    logic [SHARES-1:0][1:0] eSh;
    logic [SHARES-1:0][1:0] a1Sh;
    logic [SHARES-1:0][1:0] a0Sh;

    // Inversion is squaring in the normal basis: a per-share bit swap
    always_comb begin
        eSh  = '0;
        a1Sh = '0;
        a0Sh = '0;
        for (int i = 0; i < SHARES; i++) begin
            eSh[i]  = {bus._DxDI[2*i], bus._DxDI[2*i+1]};
            a1Sh[i] = aDelayed[4*i+2 +: 2];
            a0Sh[i] = aDelayed[4*i +: 2];
        end
    end

    logic [SHARES-1:0][1:0] innerHi;
    logic [SHARES-1:0][1:0] innerLo;
    logic [PAIRS-1:0][1:0]  crossHiI;
    logic [PAIRS-1:0][1:0]  crossHiJ;
    logic [PAIRS-1:0][1:0]  crossLoI;
    logic [PAIRS-1:0][1:0]  crossLoJ;

    // Cross-domain products get their fresh Z before the register boundary
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            innerHi  <= '0;
            innerLo  <= '0;
            crossHiI <= '0;
            crossHiJ <= '0;
            crossLoI <= '0;
            crossLoJ <= '0;
        end else begin
            for (int i = 0; i < SHARES; i++) begin
                innerHi[i] <= gf4Mul(eSh[i], a0Sh[i]);
                innerLo[i] <= gf4Mul(eSh[i], a1Sh[i]);
                for (int j = i + 1; j < SHARES; j++) begin
                    crossHiI[pairIndex(i, j)] <= gf4Mul(eSh[i], a0Sh[j])
                                                 ^ bus._ZxDI[2*pairIndex(i, j) +: 2];
                    crossHiJ[pairIndex(i, j)] <= gf4Mul(eSh[j], a0Sh[i])
                                                 ^ bus._ZxDI[2*pairIndex(i, j) +: 2];
                    crossLoI[pairIndex(i, j)] <= gf4Mul(eSh[i], a1Sh[j])
                                                 ^ bus._ZxDI[ZHALF + 2*pairIndex(i, j) +: 2];
                    crossLoJ[pairIndex(i, j)] <= gf4Mul(eSh[j], a1Sh[i])
                                                 ^ bus._ZxDI[ZHALF + 2*pairIndex(i, j) +: 2];
                end
            end
        end
    end

    logic [1:0]    accHi;
    logic [1:0]    accLo;
    logic [AW-1:0] qSum;

    // Output shares compress registered terms only
    always_comb begin
        accHi = '0;
        accLo = '0;
        qSum  = '0;
        for (int i = 0; i < SHARES; i++) begin
            accHi = innerHi[i];
            accLo = innerLo[i];
            for (int j = i + 1; j < SHARES; j++) begin
                accHi ^= crossHiI[pairIndex(i, j)];
                accLo ^= crossLoI[pairIndex(i, j)];
            end
            for (int j = 0; j < i; j++) begin
                accHi ^= crossHiJ[pairIndex(j, i)];
                accLo ^= crossLoJ[pairIndex(j, i)];
            end
            qSum[4*i +: 4] = {accHi, accLo};
        end
    end

    assign bus._QxDO = qSum;

endmodule

// File: tb/tb_shared_inv_gf4_backend.sv
// Scoreboard bench for shared_inv_gf4_backend over (SHARES, D_LATENCY) = (2,1), (3,0), (3,2),
// all driven from one cycle-indexed stimulus table of unmasked a/d values.
module tb_shared_inv_gf4_backend;
    localparam int NCYC = 2400;

    logic clk;
    logic rst;
    int   cyc;
    int   nCmp;
    int   nErr;

    logic [3:0] aTab [NCYC];
    logic [1:0] dTab [NCYC];
    bit         vTab [NCYC];
    bit         rTab [NCYC];
    int         mTab [NCYC];

    typedef struct {
        logic [3:0] expQ;
        int         due;
        int         mode;
    } sbEntry_t;

    always #5 clk = ~clk;

    task automatic tbCheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // GF(2^2) reference via discrete logs: 11 = 1, 10 = x, 01 = x^2
    function automatic int gfLog(input logic [1:0] v);
        case (v)
            2'b11:   return 0;
            2'b10:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] gfExp(input int k);
        case (k % 3)
            0:       return 2'b11;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] gfMulRef(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        return gfExp(gfLog(x) + gfLog(y));
    endfunction

    function automatic logic [1:0] gfInvRef(input logic [1:0] x);
        if (x == 2'b00) return 2'b00;
        return gfExp(3 - gfLog(x));
    endfunction

    function automatic logic [3:0] refInv(input logic [3:0] a, input logic [1:0] d);
        logic [1:0] e;
        e = gfInvRef(d);
        return {gfMulRef(e, a[1:0]), gfMulRef(e, a[3:2])};
    endfunction

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        rst = (cyc < NCYC) ? rTab[cyc] : 1'b0;
    end

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned S     = (g == 0) ? 2 : 3;
        localparam int unsigned D     = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
        localparam int unsigned ZW    = 2 * S * (S - 1);
        localparam int unsigned PAIRS = S * (S - 1) / 2;

        shared_inv_gf4_backend_if #(.SHARES(S)) bus ();

        shared_inv_gf4_backend #(
            .SHARES   (S),
            .D_LATENCY(D)
        ) dut (
            .ClkxCI(clk),
            .RstxRI(rst),
            .bus   (bus)
        );

        sbEntry_t       sbQ[$];
        sbEntry_t       ent;
        logic [4*S-1:0] qPrev;
        logic [ZW-1:0]  zSaved;
        logic [ZW-1:0]  zDelta;
        int             n;
        int             m;

        function automatic logic [4*S-1:0] splitA(input logic [3:0] v, input bit det);
            logic [4*S-1:0] r;
            logic [3:0]     acc;
            r   = '0;
            acc = v;
            for (int i = 1; i < S; i++) begin
                r[4*i +: 4] = det ? 4'h0 : 4'($urandom);
                acc ^= r[4*i +: 4];
            end
            r[3:0] = acc;
            return r;
        endfunction

        function automatic logic [2*S-1:0] splitD(input logic [1:0] v, input bit det);
            logic [2*S-1:0] r;
            logic [1:0]     acc;
            r   = '0;
            acc = v;
            for (int i = 1; i < S; i++) begin
                r[2*i +: 2] = det ? 2'b00 : 2'($urandom);
                acc ^= r[2*i +: 2];
            end
            r[1:0] = acc;
            return r;
        endfunction

        function automatic logic [3:0] recomb(input logic [4*S-1:0] q);
            logic [3:0] r;
            r = 4'h0;
            for (int i = 0; i < S; i++) r ^= q[4*i +: 4];
            return r;
        endfunction

        // Z perturbation that touches every share in both halves
        initial begin
            zDelta = '0;
            for (int h = 0; h < 2; h++) begin
                for (int k = 0; k < PAIRS && k < 2; k++) begin
                    zDelta[h*2*PAIRS + 2*k +: 2] = (k == 0) ? 2'b01 : 2'b10;
                end
            end
            zSaved       = '0;
            qPrev        = '0;
            bus.ValidxSI = 1'b0;
            bus._AxDI    = '0;
            bus._DxDI    = '0;
            bus._ZxDI    = '0;
        end

        always @(posedge clk) begin
            #2;
            n = cyc;
            if (n < NCYC) begin
                if (rTab[n-1]) begin
                    tbCheck($sformatf("c%0d_rst_valid", g), 32'(bus.ValidxSO), 32'd0);
                    tbCheck($sformatf("c%0d_rst_data", g), 32'(bus._QxDO), 32'd0);
                    sbQ.delete();
                end else if (bus.ValidxSO) begin
                    if (sbQ.size() == 0) begin
                        tbCheck($sformatf("c%0d_spurious_valid", g), 32'(bus.ValidxSO), 32'd0);
                    end else begin
                        ent = sbQ.pop_front();
                        tbCheck($sformatf("c%0d_latency", g), 32'(n), 32'(ent.due));
                        tbCheck($sformatf("c%0d_data", g), 32'(recomb(bus._QxDO)), 32'(ent.expQ));
                        if (ent.mode == 1) qPrev = bus._QxDO;
                        if (ent.mode == 2) begin
                            for (int i = 0; i < S; i++) begin
                                tbCheck($sformatf("c%0d_zvar_sh%0d", g, i),
                                        32'(bus._QxDO[4*i +: 4] != qPrev[4*i +: 4]), 32'd1);
                            end
                        end
                    end
                end else if (sbQ.size() > 0 && sbQ[0].due <= n) begin
                    tbCheck($sformatf("c%0d_missing_valid", g), 32'(bus.ValidxSO), 32'd1);
                    void'(sbQ.pop_front());
                end

                if (n == NCYC - 1) begin
                    tbCheck($sformatf("c%0d_drain", g), 32'(sbQ.size()), 32'd0);
                end

                bus.ValidxSI = vTab[n];
                bus._AxDI    = splitA(aTab[n], mTab[n] != 0);
                m = n - int'(D);
                if (m >= 0) begin
                    bus._DxDI = splitD(dTab[m], mTab[m] != 0);
                    case (mTab[m])
                        1: begin
                            zSaved    = ZW'({$urandom, $urandom});
                            bus._ZxDI = zSaved;
                        end
                        2:       bus._ZxDI = zSaved ^ zDelta;
                        3:       bus._ZxDI = '0;
                        default: bus._ZxDI = ZW'({$urandom, $urandom});
                    endcase
                end else begin
                    bus._DxDI = '0;
                    bus._ZxDI = '0;
                end

                if (vTab[n] && !rTab[n]) begin
                    ent.expQ = refInv(aTab[n], dTab[n]);
                    ent.due  = n + int'(D) + 1;
                    ent.mode = mTab[n];
                    sbQ.push_back(ent);
                end
            end
        end
    end

    initial begin
        int p;
        clk  = 1'b0;
        rst  = 1'b1;
        cyc  = 0;
        nCmp = 0;
        nErr = 0;
        for (int c = 0; c < NCYC; c++) begin
            aTab[c] = 4'h0;
            dTab[c] = 2'b00;
            vTab[c] = 1'b0;
            rTab[c] = 1'b0;
            mTab[c] = 0;
        end
        for (int c = 0; c < 3; c++) rTab[c] = 1'b1;

        // Worked example with deterministic sharing and Z = 0
        p = 4;
        aTab[p] = 4'b1011;
        dTab[p] = 2'b10;
        vTab[p] = 1'b1;
        mTab[p] = 3;
        p = 8;

        // Identity inverse: d = 1 gives {a0, a1}
        for (int i = 0; i < 1000; i++) begin
            aTab[p] = 4'($urandom);
            dTab[p] = 2'b11;
            vTab[p] = 1'b1;
            p++;
        end
        p += 3;

        // Zero d maps to zero output
        for (int i = 0; i < 50; i++) begin
            aTab[p] = 4'($urandom);
            dTab[p] = 2'b00;
            vTab[p] = 1'b1;
            p++;
        end
        p += 3;

        // Bursts of 8 separated by 3-cycle bubbles
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                aTab[p] = 4'($urandom);
                dTab[p] = 2'($urandom);
                vTab[p] = 1'b1;
                p++;
            end
            p += 3;
        end

        // Same operand and sharing twice, only Z differs
        for (int r = 0; r < 4; r++) begin
            aTab[p]     = 4'($urandom);
            dTab[p]     = 2'($urandom_range(1, 3));
            aTab[p+1]   = aTab[p];
            dTab[p+1]   = dTab[p];
            vTab[p]     = 1'b1;
            vTab[p+1]   = 1'b1;
            mTab[p]     = 1;
            mTab[p+1]   = 2;
            p += 5;
        end

        // One-cycle reset with two operands in the pipe
        aTab[p]   = 4'($urandom);
        dTab[p]   = 2'($urandom_range(1, 3));
        vTab[p]   = 1'b1;
        aTab[p+1] = 4'($urandom);
        dTab[p+1] = 2'($urandom_range(1, 3));
        vTab[p+1] = 1'b1;
        rTab[p+1] = 1'b1;
        p += 6;

        // Random traffic with random bubbles
        for (int i = 0; i < 1000; i++) begin
            aTab[p] = 4'($urandom);
            dTab[p] = 2'($urandom);
            vTab[p] = ($urandom_range(0, 3) != 0);
            p++;
        end

        wait (cyc == NCYC - 1);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
